conv_seq: RTL
=============

CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 Parameter IDX_W, default 8, width of every loop bound and loop index.
REQ-002 Parameter CNT_W, default 32, width of the issued-row statistics counter.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Reset: asynchronous, active-low.
REQ-005 start  input  1  Launch one convolution pass; sampled only in IDLE.
REQ-006 abort  input  1  Synchronous cancel of the current pass.
REQ-007 cfg_k, cfg_wcha, cfg_row, cfg_col  input  IDX_W each  Kernels, channels, ifmap rows, ifmap columns; sampled with start.
REQ-008 pe_ready  input  1  PE array can accept a new row index set.
REQ-009 idx_valid  output  1  idx_k/idx_wcha/idx_row valid for the PE array and address generator.
REQ-010 idx_k, idx_wcha, idx_row  output  IDX_W each  Current loop indices.
REQ-011 col_cnt  output  IDX_W  Column-wait counter.
REQ-012 busy  output  1  High in any state other than IDLE.
REQ-013 done  output  1  One-cycle pulse at normal completion.
REQ-014 cfg_err  output  1  One-cycle pulse when start is rejected.
REQ-015 rows_issued  output  CNT_W  Count of accepted handshakes since reset.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT_COL and DONE.
REQ-017 IDLE SHALL transition as follows: start with all cfg values nonzero -> latch cfg, clear indices, go to ISSUE next cycle; start with any cfg value zero -> cfg_err pulse next cycle, stay in IDLE.
REQ-018 In ISSUE, idx_valid SHALL be 1, and indices SHALL be held stable until pe_ready is 1.
REQ-019 A handshake (idx_valid and pe_ready in the same cycle) SHALL move the FSM to WAIT_COL with col_cnt=0 and SHALL increment rows_issued.
REQ-020 WAIT_COL SHALL increment col_cnt by 1 per cycle; the FSM SHALL leave WAIT_COL in the cycle where col_cnt==cfg_col-1, so that it occupies exactly cfg_col cycles.
REQ-021 On leaving WAIT_COL, the indices SHALL advance with row innermost, then wcha, then k, each wrapping to 0 at its bound-1.
REQ-022 Leaving WAIT_COL with k, wcha and row all at bound-1 SHALL go to DONE; otherwise it SHALL go to ISSUE.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE; indices SHALL hold their final values until the next start.
REQ-024 start SHALL be ignored outside IDLE; latched cfg SHALL be unaffected by cfg changes during a pass.
REQ-025 abort SHALL return the FSM to IDLE next cycle from any state, clear col_cnt, and assert neither done nor cfg_err; abort SHALL win over a simultaneous start or handshake.
REQ-026 idx_valid SHALL be 1 only in ISSUE, and busy SHALL be 0 only in IDLE.
REQ-027 rows_issued SHALL wrap modulo 2^CNT_W.
REQ-028 All arithmetic SHALL be unsigned, and bound comparisons SHALL use bound-1 computed at IDX_W with no overflow, since bounds are nonzero.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, all indices 0, col_cnt 0, latched cfg 0, idx_valid 0, busy 0, done 0, cfg_err 0, rows_issued 0.
REQ-030 Reset release mid-operation SHALL leave the block in IDLE with no done pulse.

Structure
REQ-031 The package conv_seq_pkg SHALL hold the state enumeration and the IDX_W/CNT_W default constants.
REQ-032 One sub-module, wrap_cnt, SHALL be used: an IDX_W counter with enable, clear, bound input and a wrap flag output, instantiated three times in a chained row/wcha/k configuration.
REQ-033 Address arithmetic SHALL remain in the address generator; conv_seq emits only indices.

Verification
REQ-034 Scenario: k=1, wcha=1, row=2, col=3, pe_ready=1, start in cycle 0 -> idx_valid in cycles 1 and 5 with idx_row=0 then 1, done pulse in cycle 9, rows_issued=2.
REQ-035 Scenario: k=2, wcha=2, row=2, col=1, pe_ready=1 -> 8 handshakes in order (k,wcha,row) = 000,001,010,011,100,101,110,111, then done.
REQ-036 Scenario: pe_ready held 0 for 5 cycles in ISSUE -> indices and idx_valid stable, col_cnt 0, rows_issued unchanged until pe_ready=1.
REQ-037 Scenario: start with cfg_col=0 -> cfg_err pulse, busy stays 0, no idx_valid.
REQ-038 Scenario: abort asserted in WAIT_COL with col_cnt=2 -> IDLE next cycle, no done; a new start then runs a full pass from indices 0.
REQ-039 Scenario: rst_n pulsed low mid-ISSUE, asynchronous to clk -> all outputs 0 immediately; start pulses during busy are ignored in a separate run.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared types and default widths for the convolution loop sequencer.
package conv_seq_pkg;

    localparam int unsigned IDX_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_COL = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/conv_seq_wrap_cnt.sv
// Loop index counter: counts 0..bound-1, wraps to 0, flags its last value.
module wrap_cnt
    import conv_seq_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [IDX_W-1:0] bound,
    output logic [IDX_W-1:0] cnt,
    output logic             wrap_c
);

    logic [IDX_W-1:0] last_c;

    // Bound is nonzero whenever the counter is enabled, so bound-1 cannot underflow.
    assign last_c = IDX_W'(bound - IDX_W'(1));
    assign wrap_c = (cnt == last_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : IDX_W'(cnt + IDX_W'(1));
        end
    end

endmodule

// File: rtl/conv_seq.sv
// Convolution loop sequencer: walks k/wcha/row indices, handing each set to the
// PE array and then waiting one ifmap row of columns before the next.
module conv_seq
    import conv_seq_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] cfg_k,
    input  logic [IDX_W-1:0] cfg_wcha,
    input  logic [IDX_W-1:0] cfg_row,
    input  logic [IDX_W-1:0] cfg_col,
    input  logic             pe_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx_k,
    output logic [IDX_W-1:0] idx_wcha,
    output logic [IDX_W-1:0] idx_row,
    output logic [IDX_W-1:0] col_cnt,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] rows_issued
);

    state_e state, state_d;

    logic [IDX_W-1:0] cfg_k_q, cfg_wcha_q, cfg_row_q, cfg_col_q;
    logic [IDX_W-1:0] col_last_c;

    logic cfg_ok_c;
    logic hs_c;
    logic latch_c;
    logic idx_clr_c;
    logic adv_c;
    logic col_clr_c;
    logic col_inc_c;
    logic cfg_err_d;
    logic row_wrap_c, wcha_wrap_c, k_wrap_c, all_wrap_c;

    assign cfg_ok_c   = (cfg_k != '0) && (cfg_wcha != '0) && (cfg_row != '0) && (cfg_col != '0);
    assign col_last_c = IDX_W'(cfg_col_q - IDX_W'(1));
    assign all_wrap_c = row_wrap_c && wcha_wrap_c && k_wrap_c;

    // Row is innermost; each outer counter steps only when all inner ones wrap.
    wrap_cnt #(.IDX_W(IDX_W)) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv_c),
        .clr    (idx_clr_c),
        .bound  (cfg_row_q),
        .cnt    (idx_row),
        .wrap_c (row_wrap_c)
    );

    wrap_cnt #(.IDX_W(IDX_W)) u_wcha (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv_c && row_wrap_c),
        .clr    (idx_clr_c),
        .bound  (cfg_wcha_q),
        .cnt    (idx_wcha),
        .wrap_c (wcha_wrap_c)
    );

    wrap_cnt #(.IDX_W(IDX_W)) u_k (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv_c && row_wrap_c && wcha_wrap_c),
        .clr    (idx_clr_c),
        .bound  (cfg_k_q),
        .cnt    (idx_k),
        .wrap_c (k_wrap_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_d   = state;
        hs_c      = 1'b0;
        latch_c   = 1'b0;
        idx_clr_c = 1'b0;
        adv_c     = 1'b0;
        col_clr_c = 1'b0;
        col_inc_c = 1'b0;
        cfg_err_d = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok_c) begin
                        state_d   = ST_ISSUE;
                        latch_c   = 1'b1;
                        idx_clr_c = 1'b1;
                        col_clr_c = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (idx_valid && pe_ready) begin
                    hs_c      = 1'b1;
                    col_clr_c = 1'b1;
                    state_d   = ST_WAIT_COL;
                end
            end
            ST_WAIT_COL: begin
                if (col_cnt == col_last_c) begin
                    col_clr_c = 1'b1;
                    // The final index set is kept on the outputs rather than wrapped.
                    if (all_wrap_c) begin
                        state_d = ST_DONE;
                    end else begin
                        adv_c   = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    col_inc_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            hs_c      = 1'b0;
            latch_c   = 1'b0;
            idx_clr_c = 1'b0;
            adv_c     = 1'b0;
            col_inc_c = 1'b0;
            col_clr_c = 1'b1;
            cfg_err_d = 1'b0;
        end
    end

    // Latched configuration, column counter, statistics and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_k_q     <= '0;
            cfg_wcha_q  <= '0;
            cfg_row_q   <= '0;
            cfg_col_q   <= '0;
            col_cnt     <= '0;
            rows_issued <= '0;
            idx_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (latch_c) begin
                cfg_k_q    <= cfg_k;
                cfg_wcha_q <= cfg_wcha;
                cfg_row_q  <= cfg_row;
                cfg_col_q  <= cfg_col;
            end
            if (col_clr_c) begin
                col_cnt <= '0;
            end else if (col_inc_c) begin
                col_cnt <= IDX_W'(col_cnt + IDX_W'(1));
            end
            if (hs_c) begin
                rows_issued <= CNT_W'(rows_issued + CNT_W'(1));
            end
            idx_valid <= (state_d == ST_ISSUE);
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            cfg_err   <= cfg_err_d;
        end
    end

endmodule
